// File: rtl/onp_lexer.sv
// onp_lexer: ASCII front end for the RPN stack calculator.
//
// Turns a byte stream of decimal numbers, separators, operators and
// newlines into stack-machine commands (push operand / apply operator),
// tracks the stack depth those commands produce, and locks into an error
// state on malformed input before a bad command can reach the stack.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_char    input byte stream
//   in_ready             byte accepted on a rising edge with in_valid high
//   cmd_valid, cmd_ready command handshake (one stack step per handshake)
//   push                 1 = push d, 0 = apply op
//   op                   01 negate, 10 add, 11 multiply, 00 peek
//   d                    push operand (0 during an op command)
//   depth                stack depth after all completed commands
//   err                  sticky error flag
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The lexer holds cmd_valid and all command fields stable
// until cmd_ready is seen; in_ready does not depend on in_valid.
module onp_lexer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        push,
  output logic [1:0]  op,
  output logic [15:0] d,
  output logic [9:0]  depth,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_NUM       = 3'd1,
    S_EMIT_PUSH = 3'd2,
    S_EMIT_OP   = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  localparam logic [1:0] OP_PEEK = 2'b00;
  localparam logic [1:0] OP_NEG  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  state_t      state, state_nx;
  logic [15:0] acc, acc_nx;
  logic [1:0]  op_q, op_nx;
  logic        pend, pend_nx;
  logic [9:0]  depth_nx;
  logic        err_nx;

  // Character classification
  logic        is_digit, is_sep, is_nl, is_arith, is_term_op;
  logic [1:0]  term_code;
  logic [3:0]  digit;
  logic        accept;
  logic [10:0] eff;
  logic [10:0] need;
  logic        op_bad;
  logic        depth_full;
  logic [15:0] acc_x10;

  assign is_digit   = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign is_sep     = (in_char == 8'h20);
  assign is_nl      = (in_char == 8'h0A);
  assign is_arith   = (in_char == 8'h2B) || (in_char == 8'h2A) || (in_char == 8'h2D);
  assign is_term_op = is_arith || is_nl;
  // Low nibble of '0'..'9' is the digit value.
  assign digit      = in_char[3:0];

  always_comb begin
    term_code = OP_PEEK;
    case (in_char)
      8'h2B:   term_code = OP_ADD;
      8'h2A:   term_code = OP_MUL;
      8'h2D:   term_code = OP_NEG;
      default: term_code = OP_PEEK;
    endcase
  end

  assign accept     = in_valid && in_ready;
  // A number still being typed will be pushed before the operator runs,
  // so it counts toward the operands available to that operator.
  assign eff        = {1'b0, depth} + {10'd0, (state == S_NUM)};
  assign need       = term_code[1] ? 11'd2 : 11'd1;
  assign op_bad     = (eff < need);
  assign depth_full = (depth == 10'd1023);
  assign acc_x10    = (acc << 3) + (acc << 1);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    op_nx    = op_q;
    pend_nx  = pend;
    depth_nx = depth;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_nx   = {12'd0, digit};
            state_nx = S_NUM;
          end else if (is_sep) begin
            state_nx = S_IDLE;
          end else if (is_term_op) begin
            if (op_bad) begin
              state_nx = S_ERR;
            end else begin
              op_nx    = term_code;
              pend_nx  = 1'b0;
              state_nx = S_EMIT_OP;
            end
          end else begin
            state_nx = S_ERR;
          end
        end
      end
      S_NUM: begin
        if (accept) begin
          if (is_digit) begin
            acc_nx = acc_x10 + {12'd0, digit};
          end else if (is_sep) begin
            if (depth_full) begin
              state_nx = S_ERR;
            end else begin
              pend_nx  = 1'b0;
              state_nx = S_EMIT_PUSH;
            end
          end else if (is_term_op) begin
            if (depth_full || op_bad) begin
              state_nx = S_ERR;
            end else begin
              op_nx    = term_code;
              pend_nx  = 1'b1;
              state_nx = S_EMIT_PUSH;
            end
          end else begin
            state_nx = S_ERR;
          end
        end
      end
      S_EMIT_PUSH: begin
        if (cmd_ready) begin
          depth_nx = depth + 10'd1;
          pend_nx  = 1'b0;
          state_nx = pend ? S_EMIT_OP : S_IDLE;
        end
      end
      S_EMIT_OP: begin
        if (cmd_ready) begin
          // Binary operators consume two entries and leave one.
          if (op_q[1]) depth_nx = depth - 10'd1;
          state_nx = S_IDLE;
        end
      end
      S_ERR: begin
        state_nx = S_ERR;
      end
      default: begin
        state_nx = S_ERR;
      end
    endcase
    err_nx = err || (state_nx == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= 16'd0;
      op_q  <= OP_PEEK;
      pend  <= 1'b0;
      depth <= 10'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      op_q  <= op_nx;
      pend  <= pend_nx;
      depth <= depth_nx;
      err   <= err_nx;
    end
  end

  // Command fields are decoded from registered state only, so they are
  // stable for the whole cycle and held while the downstream stalls.
  assign in_ready  = (state == S_IDLE) || (state == S_NUM);
  assign cmd_valid = (state == S_EMIT_PUSH) || (state == S_EMIT_OP);
  assign push      = (state == S_EMIT_PUSH);
  assign op        = (state == S_EMIT_OP) ? op_q : OP_PEEK;
  assign d         = (state == S_EMIT_PUSH) ? acc : 16'd0;

endmodule

// File: tb/tb_onp_lexer.sv
// tb_onp_lexer: directed self-checking bench for onp_lexer.
// Commands are recorded as {push, op, d} and compared against a queue of
// hand-computed expected commands.
module tb_onp_lexer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        push;
  logic [1:0]  op;
  logic [15:0] d;
  logic [9:0]  depth;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];

  onp_lexer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .push      (push),
    .op        (op),
    .d         (d),
    .depth     (depth),
    .err       (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: inputs only change just after a rising edge, so the
  // falling edge sees exactly what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) got_q.push_back({push, op, d});
  end

  function automatic logic [18:0] c_push(input logic [15:0] v);
    return {1'b1, 2'b00, v};
  endfunction

  function automatic logic [18:0] c_op(input logic [1:0] o);
    return {1'b0, o, 16'd0};
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Driver: present a byte, wait (bounded) for in_ready, transfer it.
  task automatic send_char(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_char timeout: in_ready=%0b required 1 for char 0x%02h", in_ready, c);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Wait until command traffic has drained (bounded).
  task automatic drain(input string name);
    int n = 0;
    @(negedge clk);
    while (!((in_ready || err) && !cmd_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL %s drain timeout: cmd_valid=%0b in_ready=%0b", name, cmd_valid, in_ready);
    end
  endtask

  task automatic check_cmds(input string name);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s cmd count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size()) begin
        n_fail++;
        $display("FAIL %s cmd[%0d]: missing, required %h", name, i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cmd[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_state(input string name, input logic [9:0] e_depth, input logic e_err);
    n_checks++;
    if (depth !== e_depth) begin
      n_fail++;
      $display("FAIL %s depth: got %0d required %0d", name, depth, e_depth);
    end
    n_checks++;
    if (err !== e_err) begin
      n_fail++;
      $display("FAIL %s err: got %0b required %0b", name, err, e_err);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready: got %0b required 1", name, in_ready); end
    n_checks++;
    if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL %s cmd_valid: got %0b required 0", name, cmd_valid); end
    n_checks++;
    if (push !== 1'b0) begin n_fail++; $display("FAIL %s push: got %0b required 0", name, push); end
    n_checks++;
    if (op !== 2'b00) begin n_fail++; $display("FAIL %s op: got %b required 00", name, op); end
    n_checks++;
    if (d !== 16'd0) begin n_fail++; $display("FAIL %s d: got %0d required 0", name, d); end
    check_state(name, 10'd0, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    apply_reset();
    send_str("12 3+\n");
    drain("basic");
    exp_q.push_back(c_push(16'd12));
    exp_q.push_back(c_push(16'd3));
    exp_q.push_back(c_op(2'b10));
    exp_q.push_back(c_op(2'b00));
    check_cmds("basic");
    check_state("basic", 10'd1, 1'b0);
  endtask

  // Push appears in the cycle after the terminator, op one cycle later.
  task automatic test_latency();
    apply_reset();
    send_str("6 4");
    drain("latency_pre");
    send_char("+");
    @(negedge clk);
    n_checks++;
    if ({cmd_valid, push, d} !== {1'b1, 1'b1, 16'd4}) begin
      n_fail++;
      $display("FAIL latency push: got v=%0b p=%0b d=%0d required v=1 p=1 d=4", cmd_valid, push, d);
    end
    @(negedge clk);
    n_checks++;
    if ({cmd_valid, push, op} !== {1'b1, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL latency op: got v=%0b p=%0b op=%b required v=1 p=0 op=10", cmd_valid, push, op);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency drop: cmd_valid=%0b required 0", cmd_valid);
    end
    check_state("latency", 10'd1, 1'b0);
  endtask

  task automatic test_negate();
    apply_reset();
    send_str("5-\n");
    drain("negate");
    exp_q.push_back(c_push(16'd5));
    exp_q.push_back(c_op(2'b01));
    exp_q.push_back(c_op(2'b00));
    check_cmds("negate");
    check_state("negate", 10'd1, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    send_str("70000 ");
    drain("wrap");
    exp_q.push_back(c_push(16'd4464));
    check_cmds("wrap");
    check_state("wrap", 10'd1, 1'b0);
  endtask

  task automatic test_back_pressure();
    apply_reset();
    send_str("1 ");
    drain("bp_pre");
    got_q.delete();
    cmd_ready = 1'b0;
    send_str("9*");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({cmd_valid, push, d} !== {1'b1, 1'b1, 16'd9}) begin
        n_fail++;
        $display("FAIL bp hold[%0d]: got v=%0b p=%0b d=%0d required v=1 p=1 d=9", i, cmd_valid, push, d);
      end
    end
    @(posedge clk); #1 cmd_ready = 1'b1;
    drain("bp");
    exp_q.push_back(c_push(16'd9));
    exp_q.push_back(c_op(2'b11));
    check_cmds("bp");
    check_state("bp", 10'd1, 1'b0);
  endtask

  task automatic test_err_operand();
    apply_reset();
    send_str("3 +");
    @(negedge clk);
    n_checks++;
    if ({err, in_ready, cmd_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL err_operand flags: got err/in_ready/cmd_valid=%b required 100", {err, in_ready, cmd_valid});
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL err_operand in_ready: got %0b required 0", in_ready);
    end
    exp_q.push_back(c_push(16'd3));
    check_cmds("err_operand");
    check_state("err_operand", 10'd1, 1'b1);
    apply_reset();
    check_reset_outputs("err_operand_reset");
  endtask

  task automatic test_err_invalid();
    apply_reset();
    send_char("a");
    repeat (3) @(negedge clk);
    check_cmds("err_invalid");
    check_state("err_invalid", 10'd0, 1'b1);
  endtask

  // A pending push is dropped when its terminating operator underflows.
  task automatic test_err_pending();
    apply_reset();
    send_str("1+");
    repeat (3) @(negedge clk);
    check_cmds("err_pending");
    check_state("err_pending", 10'd0, 1'b1);
  endtask

  task automatic test_depth_full();
    apply_reset();
    for (int i = 0; i < 1023; i++) send_str("1 ");
    drain("full_pre");
    check_state("full_pre", 10'd1023, 1'b0);
    got_q.delete();
    send_str("7 ");
    repeat (3) @(negedge clk);
    check_cmds("full");
    check_state("full", 10'd1023, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; cmd_ready = 1'b1;
    test_reset();
    test_basic();
    test_latency();
    test_negate();
    test_wrap();
    test_back_pressure();
    test_err_operand();
    test_err_invalid();
    test_err_pending();
    test_depth_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onp_lexer.md
# onp_lexer

Upstream front end for the RPN (ONP) stack calculator. Consumes an ASCII character stream, one byte per handshake, and converts it into stack-machine commands: a push with a 16-bit operand, or an operator code. It tracks the resulting stack depth so it can stop on malformed input before a bad command reaches the stack. Each accepted command maps to exactly one stack step.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_char holds a byte
- in_char  in  8  ASCII input byte
- in_ready  out  1  lexer accepts in_char this cycle
- cmd_valid  out  1  command outputs are valid
- cmd_ready  in  1  downstream takes the command this cycle (one stack step)
- push  out  1  1 = push d; 0 = apply op
- op  out  2  01 negate top, 10 add, 11 multiply, 00 peek (no stack change)
- d  out  16  operand for push
- depth  out  10  stack depth after all completed commands
- err  out  1  sticky error flag

## Operation
- Character classes:
  - '0'–'9': digit.
  - ' ' (0x20): separator.
  - '\n' (0x0A): end of expression.
  - '+' → op 10.
  - '*' → op 11.
  - '-' → op 01 (unary negate).
  - Any other byte is invalid.
- Accumulator: acc is 16-bit. For each digit, acc <= acc*10 + digit, modulo 2^16, so "70000" pushes 4464. The first digit of a number loads acc directly.
- States:
  - IDLE: no number in progress.
    - digit → NUM.
    - separator → IDLE, no output.
    - operator → EMIT_OP.
    - '\n' → EMIT_OP with op 00.
  - NUM: number in progress.
    - digit → NUM.
    - separator → EMIT_PUSH.
    - operator or '\n' → EMIT_PUSH, with that op latched as pending.
  - EMIT_PUSH: push=1, d=acc, cmd_valid=1. On handshake, go to EMIT_OP if an op is pending, else IDLE.
  - EMIT_OP: push=0, op=latched code, d=0, cmd_valid=1. On handshake → IDLE.
  - ERR: absorbing. Only rst leaves it.
- in_ready=1 only in IDLE and NUM; 0 in EMIT_PUSH, EMIT_OP and ERR.
- Depth: updates on each completed command (cmd_valid && cmd_ready).
  - push: +1.
  - add or multiply: −1.
  - negate or peek: unchanged.
- Error checks are made when a character is accepted. eff = depth + (1 if state is NUM else 0).
  - add or multiply with eff < 2 → ERR.
  - negate or peek with eff < 1 → ERR.
  - A number terminating, by any terminator, while depth = 1023 → ERR.
  - Invalid byte → ERR.
- On entering ERR: err=1 and no command is emitted, including a pending push from the same character.

## Timing
- Reset values: state IDLE, acc 0, depth 0, err 0, cmd_valid 0, push 0, op 00, d 0, in_ready 1 (IDLE).
- A character is accepted on the edge where in_valid && in_ready. The resulting command has cmd_valid=1 from the next cycle.
- Command outputs are registered and held stable while cmd_valid && !cmd_ready. cmd_valid drops the cycle after the handshake, unless a pending op follows; then the op command is presented in the next cycle.
- Throughput: one digit per cycle. A terminator costs 1 cycle plus the emit cycles (push, op, or both) at minimum.
- Overall latency: a number terminated by an operator gives the push at accept+1 and the op at accept+2, assuming cmd_ready stays high.
- depth and err are registered and become visible one cycle after the causing edge.
- rst mid-command drops cmd_valid in the next cycle and discards acc and any pending op. The downstream stack must be reset alongside.

## Test plan
- "12 3+\n" with cmd_ready=1 → push 12, push 3, op 10, op 00. Depth goes 1, 2, 1, 1. err stays 0.
- "5-\n" → push 5, op 01, op 00. Final depth 1.
- "70000 " → push with d=4464 (wrap modulo 2^16).
- "3 +" → err=1 at accept of '+' +1 cycle. No op emitted. in_ready stays 0 until rst; after rst, all outputs are at reset values.
- "9*" at depth 1 with cmd_ready held 0 for 3 cycles → push 9 held stable for 3 cycles. Then op 11 follows the handshake. Final depth 1.
- "a" → err=1, no command. After 1023 pushes, "7 " → err=1 and depth stays 1023.
